// File: rtl/motor_pwm_ramp.sv
// Multi-channel H-bridge PWM driver: one shared period counter, per-channel duty
// ramping toward a commanded target, and ramp-down plus coast dead time on reversal.
module motor_pwm_ramp #(
  parameter int CHANNELS     = 2,
  parameter int PERIOD       = 1000000,
  parameter int CNT_W        = 20,
  parameter int STEP         = 50000,
  parameter int DEAD_PERIODS = 4,
  parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                estop,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CH_W-1:0]     cmd_ch,
  input  logic                cmd_dir,
  input  logic [CNT_W-1:0]    cmd_duty,
  output logic                cmd_err,
  output logic                period_start,
  output logic [CHANNELS-1:0] motor_pwm,
  output logic [CHANNELS-1:0] motor_in1,
  output logic [CHANNELS-1:0] motor_in2
);

  localparam int unsigned      NCH       = CHANNELS;
  localparam int               DC_W      = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [CNT_W-1:0] PERIOD_V  = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] LAST_V    = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] STEP_V    = CNT_W'(STEP);
  localparam logic [DC_W-1:0]  DEAD_INIT = DC_W'(DEAD_PERIODS - 1);

  typedef enum logic {RUN, DEAD} state_t;

  logic [CNT_W-1:0] cnt_q;
  logic             wrap;
  logic             accept;
  logic             cmd_in_range;
  logic [CNT_W-1:0] cmd_duty_sat;

  logic [CNT_W-1:0] tgt_duty_q [CHANNELS];
  logic [CNT_W-1:0] tgt_duty_d [CHANNELS];
  logic             tgt_dir_q  [CHANNELS];
  logic             tgt_dir_d  [CHANNELS];
  logic [CNT_W-1:0] cur_duty_q [CHANNELS];
  logic [CNT_W-1:0] cur_duty_d [CHANNELS];
  logic             cur_dir_q  [CHANNELS];
  logic             cur_dir_d  [CHANNELS];
  state_t           state_q    [CHANNELS];
  state_t           state_d    [CHANNELS];
  logic [DC_W-1:0]  dead_cnt_q [CHANNELS];
  logic [DC_W-1:0]  dead_cnt_d [CHANNELS];

  assign wrap         = (cnt_q == LAST_V);
  assign accept       = cmd_valid && cmd_ready && !estop;
  assign cmd_in_range = (32'(cmd_ch) < NCH);
  assign cmd_duty_sat = (cmd_duty > PERIOD_V) ? PERIOD_V : cmd_duty;
  assign period_start = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      cmd_ready <= 1'b0;
      cmd_err   <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        tgt_duty_q[i] <= '0;
        tgt_dir_q[i]  <= 1'b0;
        cur_duty_q[i] <= '0;
        cur_dir_q[i]  <= 1'b0;
        state_q[i]    <= RUN;
        dead_cnt_q[i] <= '0;
      end
    end else begin
      cnt_q     <= wrap ? '0 : cnt_q + 1'b1;
      cmd_ready <= !estop;
      cmd_err   <= accept && !cmd_in_range;
      for (int unsigned i = 0; i < NCH; i++) begin
        tgt_duty_q[i] <= tgt_duty_d[i];
        tgt_dir_q[i]  <= tgt_dir_d[i];
        cur_duty_q[i] <= cur_duty_d[i];
        cur_dir_q[i]  <= cur_dir_d[i];
        state_q[i]    <= state_d[i];
        dead_cnt_q[i] <= dead_cnt_d[i];
      end
    end
  end

  // Boundary decisions use the pre-edge targets, so a command landing on the
  // wrap edge only takes effect at the following boundary.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      tgt_duty_d[i] = tgt_duty_q[i];
      tgt_dir_d[i]  = tgt_dir_q[i];
      cur_duty_d[i] = cur_duty_q[i];
      cur_dir_d[i]  = cur_dir_q[i];
      state_d[i]    = state_q[i];
      dead_cnt_d[i] = dead_cnt_q[i];

      if (accept && cmd_in_range && (32'(cmd_ch) == i)) begin
        tgt_duty_d[i] = cmd_duty_sat;
        tgt_dir_d[i]  = cmd_dir;
      end

      if (wrap) begin
        case (state_q[i])
          DEAD: begin
            if (dead_cnt_q[i] == '0) begin
              cur_dir_d[i] = tgt_dir_q[i];
              state_d[i]   = RUN;
            end else begin
              dead_cnt_d[i] = dead_cnt_q[i] - 1'b1;
            end
          end
          default: begin
            if (tgt_dir_q[i] != cur_dir_q[i]) begin
              if (cur_duty_q[i] != '0) begin
                cur_duty_d[i] = (cur_duty_q[i] > STEP_V) ? cur_duty_q[i] - STEP_V : '0;
              end else begin
                state_d[i]    = DEAD;
                dead_cnt_d[i] = DEAD_INIT;
              end
            end else if (cur_duty_q[i] < tgt_duty_q[i]) begin
              cur_duty_d[i] = (tgt_duty_q[i] - cur_duty_q[i] > STEP_V)
                            ? cur_duty_q[i] + STEP_V : tgt_duty_q[i];
            end else if (cur_duty_q[i] > tgt_duty_q[i]) begin
              cur_duty_d[i] = (cur_duty_q[i] - tgt_duty_q[i] > STEP_V)
                            ? cur_duty_q[i] - STEP_V : tgt_duty_q[i];
            end
          end
        endcase
      end

      if (estop) begin
        cur_duty_d[i] = '0;
        tgt_duty_d[i] = '0;
        state_d[i]    = RUN;
        dead_cnt_d[i] = '0;
      end
    end
  end

  always_comb begin
    motor_pwm = '0;
    motor_in1 = '0;
    motor_in2 = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      motor_pwm[i] = (cnt_q < cur_duty_q[i]);
      motor_in1[i] = (state_q[i] == RUN) && (cur_duty_q[i] != '0) && !cur_dir_q[i];
      motor_in2[i] = (state_q[i] == RUN) && (cur_duty_q[i] != '0) &&  cur_dir_q[i];
    end
  end

endmodule
